vga_scan_controller: RTL

Raster timing generator for the 640x480 @ 60 Hz display path. Divides the 50 MHz system clock down to the pixel rate. Produces the `DrawX`/`DrawY` scan coordinates consumed by the color mapper, plus the sync and blank strobes driven to the VGA DAC. Also emits a once-per-frame pulse that paces tile motion updates.

---
 rtl/vga_scan_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_scan_controller.sv
// Raster timing generator: divides Clk to the pixel rate and produces scan
// coordinates, active-low syncs, blank and a once-per-frame pulse.
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic             frame_q, frame_d, vclk_q, vclk_d;
  logic             pix_ce;

  // Counters advance once per pixel; both wrap together at the frame corner.
  always_comb begin
    pix_ce = (div_q == DIV_LAST);
    div_d  = pix_ce ? '0 : div_q + 1'b1;
    x_d    = x_q;
    y_d    = y_q;
    if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decodes look at next-state counters so every output flips on the same edge.
  always_comb begin
    hs_d      = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d      = !((y_d >= VS_START) && (y_d < VS_END));
    blank_n_d = (x_d < H_VIS) && (y_d < V_VIS);
    frame_d   = pix_ce && (x_d == '0) && (y_d == '0);
  end

  generate
    if (CLK_DIV == 1) begin : g_div1
      assign vclk_d = 1'b1;
    end else begin : g_divn
      assign vclk_d = (div_d >= DIV_HALF);
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b1;
      frame_q   <= 1'b0;
      vclk_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      frame_q   <= frame_d;
      vclk_q    <= vclk_d;
    end
  end

  assign VGA_CLK     = vclk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_start = frame_q;

endmodule
